rptr_empty_lvl: RTL
===================

// Module: rptr_empty_lvl
// PURPOSE
//  Read-domain pointer/flag generator for the async FIFO.
//  It keeps the binary/Gray read pointer and a registered empty flag.
//  It also reports a registered fill level and a programmable almost-empty flag.
//  It sits in the read clock domain, after the 2-FF synchroniser of the write Gray pointer.
// PARAMETERS
//  ADDRSIZE  3   memory address width; DEPTH = 2**ADDRSIZE (localparam)
//  LVLSIZE   -   localparam = ADDRSIZE+1; width of level and threshold
// PORTS
//  rclk        in   1           read clock
//  rrst_n      in   1           async active-low reset
//  rinc        in   1           read request
//  rq2_wptr    in   ADDRSIZE+1  synchronised write Gray pointer
//  rae_thresh  in   ADDRSIZE+1  almost-empty threshold; quasi-static
//  rufl_clr    in   1           clear sticky underflow
//  raddr       out  ADDRSIZE    memory read address (binary)
//  rptr        out  ADDRSIZE+1  read Gray pointer, to write-domain sync
//  rempty      out  1           FIFO empty
//  rarempty    out  1           almost empty: level <= rae_thresh
//  rlevel      out  ADDRSIZE+1  entries available, 0..DEPTH
//  runderflow  out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, rrst_n=0):
//    rbin=0, rptr=0, raddr=0, rempty=1, rarempty=1, rlevel=0, runderflow=0.
//    Reset mid-operation discards all state immediately; no pending read survives.
//  - rd_ok = rinc & ~rempty.
//    rbinnext = rbin + rd_ok, mod 2**(ADDRSIZE+1).
//    rgraynext = (rbinnext>>1) ^ rbinnext.
//    Both registered each rclk. raddr = rbin[ADDRSIZE-1:0], so it is valid in the same cycle as rempty=0.
//  - wbin = gray2bin(rq2_wptr), combinational.
//    lvlnext = wbin - rbinnext, mod 2**(ADDRSIZE+1); range 0..DEPTH.
//  - Registered flags, all with 1-cycle latency from rinc/rq2_wptr change:
//    rempty <= (rgraynext == rq2_wptr).
//    rlevel <= lvlnext.
//    rarempty <= (lvlnext <= rae_thresh).
//  - Invariant: rempty == (rlevel == 0) in every cycle.
//  - rinc while rempty=1: pointer holds.
//  - Simultaneous rinc and rq2_wptr advance: both are applied.
//    The level is the net result (e.g. +1-1 leaves it unchanged).
//  - Wrap: pointer MSB toggles every DEPTH reads.
//    The level stays correct across the 2*DEPTH-1 -> 0 wrap.
//  - Full FIFO (wbin - rbin = DEPTH): rlevel = DEPTH. rlevel never exceeds DEPTH.
//  - rae_thresh = 0 makes rarempty == rempty.
//  - rae_thresh >= DEPTH holds rarempty at 1.
// CONFIGURATION
//  RPTR_UFLOW_EN defined:
//    runderflow <= 1 when rinc & rempty.
//    It clears on rufl_clr; set wins over a simultaneous clear.
//  RPTR_UFLOW_EN undefined:
//    runderflow is tied to 1'b0 and rufl_clr is ignored.
//    The underflow logic is removed; the port list is unchanged.
// STRUCTURE
//  - Shared package fifo_ptr_pkg holds:
//    functions bin2gray/gray2bin, parametrised on width;
//    the pointer-width convention ADDRSIZE+1 used by the write-side block.
//  - Sub-module gray2bin (ADDRSIZE+1 wide, combinational XOR prefix).
//    The write-side full/level block reuses it.
//  - All flag registers are in this module. No other clock domain is touched.
// TESTING (ADDRSIZE=3, DEPTH=8)
//  1. Reset with rae_thresh=1:
//     -> rempty=1, rarempty=1, rlevel=0, rptr=0, raddr=0, runderflow=0.
//  2. rq2_wptr steps to gray 4'b0110 (bin 4), rae_thresh=2:
//     -> next cycle rempty=0, rlevel=4, rarempty=0.
//  3. Then 4 back-to-back rinc:
//     -> raddr 0,1,2,3; rlevel 3,2,1,0; rarempty rises when rlevel=2;
//     -> rempty=1 with rlevel=0; rptr=4'b0110.
//  4. Wrap: interleave writes/reads for 20 entries:
//     -> rptr passes gray 4'b1000 -> 4'b0000; rlevel always equals model; no spurious rempty.
//  5. rq2_wptr 8 ahead (bin 8, gray 4'b1100):
//     -> rlevel=8, rempty=0.
//     Then rinc and wptr+1 in the same cycle -> rlevel stays 8.
//  6. rinc while empty:
//     -> rptr unchanged; runderflow=1 (macro on) or 0 (off).
//     rufl_clr with rinc&rempty in the same cycle -> runderflow stays 1.
//     Then assert rrst_n=0 mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: pointer-width convention and Gray/binary helpers shared by both FIFO pointer blocks.
// The helpers work at any width up to 32 bits, provided the unused upper bits are zero.
package fifo_ptr_pkg;
  localparam int PTR_EXTRA = 1;
  function automatic int ptr_width(input int addrsize);
    return addrsize + PTR_EXTRA;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-side pointer, empty/almost-empty flags and fill level of the async FIFO.
// Define RPTR_UFLOW_EN to build the sticky underflow flag; otherwise runderflow is tied low.
module rptr_empty_lvl #(
  parameter int ADDRSIZE = 3
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  input  logic                rufl_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rarempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);
  localparam int PW = fifo_ptr_pkg::ptr_width(ADDRSIZE);
  localparam int LVLSIZE = PW;
  logic [PW-1:0] rbin, rbinnext, rgraynext, wbin;
  logic [LVLSIZE-1:0] lvlnext;
  logic rd_ok;
  gray2bin #(.W(PW)) u_wg2b (.gray(rq2_wptr), .bin(wbin));
  assign rd_ok = rinc & ~rempty;
  assign rbinnext = rbin + PW'(rd_ok);
  assign rgraynext = PW'(fifo_ptr_pkg::bin2gray(32'(rbinnext)));
  // Modulo subtraction stays correct across the pointer wrap; the extra MSB lets it reach DEPTH.
  assign lvlnext = wbin - rbinnext;
  assign raddr = rbin[ADDRSIZE-1:0];
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      rarempty <= 1'b1;
      rlevel   <= '0;
    end else begin
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      rempty   <= (rgraynext == rq2_wptr);
      rarempty <= (lvlnext <= rae_thresh);
      rlevel   <= lvlnext;
    end
  end
`ifdef RPTR_UFLOW_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) runderflow <= 1'b0;
    else runderflow <= (rinc & rempty) | (runderflow & ~rufl_clr);
  end
`else
  logic unused_ufl_clr;
  assign unused_ufl_clr = rufl_clr;
  assign runderflow = 1'b0;
`endif
endmodule
